apb_slave_regfile: RTL and testbench

//  APB3 completer on the far end of the team's APB master bus. Decodes psel/penable

---
 rtl/apb_pkg.sv | 12 +
 rtl/apb_slv_regbank.sv | 44 ++++
 rtl/apb_slave_regfile.sv | 102 ++++++++++
 tb/tb_apb_slave_regfile.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-file completer: FSM state encoding and wait counter width.
package apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_SETUP  = 3'b010,
    ST_ACCESS = 3'b100
  } apb_state_e;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_slv_regbank.sv
// Register bank for the APB completer: reset-cleared flop array, single write port,
// read mux on the same index, and a flattened view of every register.
module apb_slv_regbank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_NUM    = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          we_i,
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic [REG_NUM*DATA_WIDTH-1:0] reg_flat_o
);

  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];

  // NOTE: this bank is built from flops with a defined power-on value, so every entry is
  // cleared in reset; a RAM macro would instead be left unreset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (addr_i == ADDR_WIDTH'(i)) regs_q[i] <= wdata_i;
      end
    end
  end

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (addr_i == ADDR_WIDTH'(i)) rdata_o = regs_q[i];
    end
  end

  always_comb begin
    reg_flat_o = '0;
    for (int i = 0; i < REG_NUM; i++) reg_flat_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer serving a bank of REG_NUM registers with WAIT_CYCLES wait states.
// Optional feature macro: APB_SLV_PSLVERR_EN (pslverr on out-of-range accesses).
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int REG_NUM     = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [ADDR_WIDTH-1:0]         paddr,
  input  logic [DATA_WIDTH-1:0]         pwdata,
  output logic [DATA_WIDTH-1:0]         prdata,
  output logic                          pready,
  output logic                          pslverr,
  output logic [REG_NUM*DATA_WIDTH-1:0] reg_flat,
  output logic                          wr_pulse,
  output logic [ADDR_WIDTH-1:0]         wr_idx
);

  apb_state_e            state_q;
  logic [WAIT_CNT_W-1:0] cnt_q;
  logic                  wr_pulse_q;
  logic [ADDR_WIDTH-1:0] wr_idx_q;

  logic                  active;
  logic                  done;
  logic                  in_range;
  logic                  commit_wr;
  logic [DATA_WIDTH-1:0] rd_data;

  // SETUP is entered on the edge that closes the bus setup phase, so SETUP and ACCESS both
  // cover access-phase cycles; the counter runs in both, giving WAIT_CYCLES+2 bus cycles.
  assign active    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign done      = active && psel && penable && (cnt_q == '0);
  assign in_range  = {1'b0, paddr} < (ADDR_WIDTH + 1)'(REG_NUM);
  assign commit_wr = done && pwrite && in_range;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_pulse_q <= 1'b0;
      wr_idx_q   <= '0;
    end else begin
      wr_pulse_q <= commit_wr;
      if (commit_wr) wr_idx_q <= paddr;

      unique case (state_q)
        ST_IDLE: begin
          if (psel && !penable) begin
            state_q <= ST_SETUP;
            cnt_q   <= WAIT_CNT_W'(WAIT_CYCLES);
          end
        end
        ST_SETUP, ST_ACCESS: begin
          // A completed transfer or a master abort both release the bus; a following setup
          // phase is picked up from IDLE in the very next cycle.
          if (!psel || done) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_ACCESS;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  apb_slv_regbank #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_NUM    (REG_NUM)
  ) u_regbank (
    .clk        (clk),
    .rstn       (rstn),
    .we_i       (commit_wr),
    .addr_i     (paddr),
    .wdata_i    (pwdata),
    .rdata_o    (rd_data),
    .reg_flat_o (reg_flat)
  );

  assign pready   = done;
  assign prdata   = (done && !pwrite && in_range) ? rd_data : '0;
  assign wr_pulse = wr_pulse_q;
  assign wr_idx   = wr_idx_q;

`ifdef APB_SLV_PSLVERR_EN
  assign pslverr = done && !in_range;
`else
  assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: one instance with 2 wait states, one with none.
// Expected pslverr follows APB_SLV_PSLVERR_EN as defined for the build.
module tb_apb_slave_regfile;
  import apb_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int RN = 16;
`ifdef APB_SLV_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_rd;
    bit            exp_pulse;
    bit            exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // Index 0: WAIT_CYCLES=2 instance, index 1: WAIT_CYCLES=0 instance.
  logic [1:0]             psel_b, penable_b, pwrite_b, pready_b, pslverr_b, wr_pulse_b;
  logic [1:0][AW-1:0]     paddr_b, wr_idx_b;
  logic [1:0][DW-1:0]     pwdata_b, prdata_b;
  logic [1:0][RN*DW-1:0]  reg_flat_b;

  int            checks = 0;
  int            errors = 0;
  int            pulse_cnt [2];
  logic [DW-1:0] mem [2][RN];

  apb_slave_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_NUM(RN), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rstn(rstn), .psel(psel_b[0]), .penable(penable_b[0]), .pwrite(pwrite_b[0]),
    .paddr(paddr_b[0]), .pwdata(pwdata_b[0]), .prdata(prdata_b[0]), .pready(pready_b[0]),
    .pslverr(pslverr_b[0]), .reg_flat(reg_flat_b[0]), .wr_pulse(wr_pulse_b[0]),
    .wr_idx(wr_idx_b[0])
  );

  apb_slave_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_NUM(RN), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rstn(rstn), .psel(psel_b[1]), .penable(penable_b[1]), .pwrite(pwrite_b[1]),
    .paddr(paddr_b[1]), .pwdata(pwdata_b[1]), .prdata(prdata_b[1]), .pready(pready_b[1]),
    .pslverr(pslverr_b[1]), .reg_flat(reg_flat_b[1]), .wr_pulse(wr_pulse_b[1]),
    .wr_idx(wr_idx_b[1])
  );

  initial begin
    pulse_cnt[0] = 0;
    pulse_cnt[1] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) if (wr_pulse_b[i]) pulse_cnt[i]++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RN*DW-1:0] model_flat(input int b);
    logic [RN*DW-1:0] f;
    f = '0;
    for (int i = 0; i < RN; i++) f[i*DW +: DW] = mem[b][i];
    return f;
  endfunction

  // One APB transfer; returns at the completion cycle (negedge) so a held psel continues
  // straight into the next setup phase.
  task automatic xfer(input int b, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit hold, output logic [DW-1:0] rd, output logic err,
                      output int cyc);
    bit got;
    @(posedge clk); #1;
    psel_b[b] = 1'b1; penable_b[b] = 1'b0; pwrite_b[b] = wr; paddr_b[b] = a; pwdata_b[b] = d;
    cyc = 1;
    @(negedge clk);
    check("setup pready", pready_b[b], 1'b0);
    @(posedge clk); #1;
    penable_b[b] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      cyc++;
      @(negedge clk);
      if (pready_b[b]) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!got) check("pready timeout", pready_b[b], 1'b1);
    rd  = prdata_b[b];
    err = pslverr_b[b];
    if (!hold || !got) begin
      @(posedge clk); #1;
      psel_b[b] = 1'b0; penable_b[b] = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs [12];
    logic [DW-1:0] rd;
    logic          err;
    int            cyc;
    int            base;
    int            exp_pulses;

    vecs[0]  = '{0, 8'd3,   8'h00, 8'h00, 0, 0};
    vecs[1]  = '{1, 8'd5,   8'hA5, 8'h00, 1, 0};
    vecs[2]  = '{0, 8'd5,   8'h00, 8'hA5, 0, 0};
    vecs[3]  = '{1, 8'd20,  8'h11, 8'h00, 0, ERR_EN};
    vecs[4]  = '{0, 8'd20,  8'h00, 8'h00, 0, ERR_EN};
    vecs[5]  = '{1, 8'd15,  8'h7E, 8'h00, 1, 0};
    vecs[6]  = '{1, 8'd16,  8'h99, 8'h00, 0, ERR_EN};
    vecs[7]  = '{0, 8'd15,  8'h00, 8'h7E, 0, 0};
    vecs[8]  = '{0, 8'd16,  8'h00, 8'h00, 0, ERR_EN};
    vecs[9]  = '{1, 8'd0,   8'hC3, 8'h00, 1, 0};
    vecs[10] = '{0, 8'd0,   8'h00, 8'hC3, 0, 0};
    vecs[11] = '{0, 8'd255, 8'h00, 8'h00, 0, ERR_EN};

    for (int b = 0; b < 2; b++) for (int i = 0; i < RN; i++) mem[b][i] = '0;
    psel_b = '0; penable_b = '0; pwrite_b = '0; paddr_b = '0; pwdata_b = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rstn = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst pready",   pready_b,      2'b00);
    check("rst prdata",   prdata_b,      '0);
    check("rst pslverr",  pslverr_b,     2'b00);
    check("rst wr_pulse", wr_pulse_b,    2'b00);
    check("rst wr_idx",   wr_idx_b,      '0);
    check("rst reg_flat", reg_flat_b[0], '0);
    check("rst state",    dut.state_q,   ST_IDLE);

    // Directed vectors on the 2-wait-state instance
    for (int i = 0; i < 12; i++) begin
      xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0, rd, err, cyc);
      if (vecs[i].wr && vecs[i].addr < AW'(RN)) mem[0][vecs[i].addr] = vecs[i].data;
      check($sformatf("vec%0d cycles", i), cyc, 4);
      check($sformatf("vec%0d prdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d pslverr", i), err, vecs[i].exp_err);
      @(negedge clk);
      check($sformatf("vec%0d wr_pulse", i), wr_pulse_b[0], vecs[i].exp_pulse);
      if (vecs[i].exp_pulse) check($sformatf("vec%0d wr_idx", i), wr_idx_b[0], vecs[i].addr);
      @(negedge clk);
      check($sformatf("vec%0d wr_pulse once", i), wr_pulse_b[0], 1'b0);
    end
    check("reg5 slice", reg_flat_b[0][47:40], 8'hA5);
    check("vec reg_flat", reg_flat_b[0], model_flat(0));

    // Zero-wait back-to-back writes then reads
    base = pulse_cnt[1];
    for (int i = 0; i < RN; i++) begin
      xfer(1, 1'b1, AW'(i), DW'(i), i != RN - 1, rd, err, cyc);
      mem[1][i] = DW'(i);
      check($sformatf("b2b wr%0d cycles", i), cyc, 2);
    end
    repeat (2) @(posedge clk); #1;
    check("b2b wr pulses", pulse_cnt[1] - base, RN);
    for (int i = 0; i < RN; i++) begin
      xfer(1, 1'b0, AW'(i), '0, i != RN - 1, rd, err, cyc);
      check($sformatf("b2b rd%0d data", i), rd, DW'(i));
      check($sformatf("b2b rd%0d cycles", i), cyc, 2);
    end
    check("b2b reg_flat", reg_flat_b[1], model_flat(1));

    // Master abort during wait states of a write to idx 2
    base = pulse_cnt[0];
    @(posedge clk); #1;
    psel_b[0] = 1'b1; penable_b[0] = 1'b0; pwrite_b[0] = 1'b1; paddr_b[0] = 8'd2; pwdata_b[0] = 8'h5A;
    @(posedge clk); #1;
    penable_b[0] = 1'b1;
    @(negedge clk);
    check("abort wait pready", pready_b[0], 1'b0);
    @(posedge clk); #1;
    psel_b[0] = 1'b0; penable_b[0] = 1'b0;
    @(negedge clk);
    check("abort drop pready", pready_b[0], 1'b0);
    @(negedge clk);
    check("abort state", dut.state_q, ST_IDLE);
    repeat (2) @(posedge clk); #1;
    check("abort reg_flat", reg_flat_b[0], model_flat(0));
    check("abort pulses", pulse_cnt[0] - base, 0);
    xfer(0, 1'b1, 8'd2, 8'h5A, 1'b0, rd, err, cyc);
    mem[0][2] = 8'h5A;
    check("post-abort cycles", cyc, 4);
    xfer(0, 1'b0, 8'd2, '0, 1'b0, rd, err, cyc);
    check("post-abort read", rd, 8'h5A);

    // Randomized traffic against the array model
    base = pulse_cnt[0];
    exp_pulses = 0;
    for (int k = 0; k < 60; k++) begin
      bit            wr;
      int            a;
      logic [DW-1:0] d;
      logic [DW-1:0] exp_rd;
      bit            hold;
      wr   = 1'($urandom_range(0, 1));
      a    = int'($urandom_range(0, 23));
      d    = DW'($urandom);
      hold = ($urandom_range(0, 3) == 0) && (k != 59);
      xfer(0, wr, AW'(a), d, hold, rd, err, cyc);
      exp_rd = (!wr && a < RN) ? mem[0][a] : '0;
      if (wr && a < RN) begin
        mem[0][a] = d;
        exp_pulses++;
      end
      check($sformatf("rand%0d prdata", k), rd, exp_rd);
      check($sformatf("rand%0d pslverr", k), err, ERR_EN && (a >= RN));
      check($sformatf("rand%0d cycles", k), cyc, 4);
    end
    repeat (3) @(posedge clk); #1;
    check("rand pulses", pulse_cnt[0] - base, exp_pulses);
    check("rand reg_flat", reg_flat_b[0], model_flat(0));

    // Reset asserted during the access phase of a write 0x3C to idx 1
    @(posedge clk); #1;
    psel_b[0] = 1'b1; penable_b[0] = 1'b0; pwrite_b[0] = 1'b1; paddr_b[0] = 8'd1; pwdata_b[0] = 8'h3C;
    @(posedge clk); #1;
    penable_b[0] = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst pready", pready_b[0], 1'b0);
    check("midrst reg_flat", reg_flat_b[0], '0);
    check("midrst state", dut.state_q, ST_IDLE);
    repeat (2) @(posedge clk); #1;
    psel_b[0] = 1'b0; penable_b[0] = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int b = 0; b < 2; b++) for (int i = 0; i < RN; i++) mem[b][i] = '0;
    repeat (2) @(posedge clk); #1;
    check("postrst reg_flat", reg_flat_b[0], model_flat(0));
    check("postrst wr_pulse", wr_pulse_b[0], 1'b0);
    xfer(0, 1'b0, 8'd1, '0, 1'b0, rd, err, cyc);
    check("postrst read idx1", rd, 8'h00);
    check("postrst cycles", cyc, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
